// File: rtl/led_framebuf.sv
// Double-buffered 64-row LED panel framebuffer: scanner reads the front bank,
// writes/clears go to the back bank, and swaps are deferred to frame_sync.

module fb_ram #(
  parameter int DW = 24,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // Only the read register is reset; array contents survive reset.
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
endmodule

module led_framebuf #(
  parameter int COLOR_BITS = 8,
  parameter int PANEL_W    = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              addrx,
  input  logic [4:0]              addry,
  input  logic                    frame_sync,
  output logic [COLOR_BITS-1:0]   r0,
  output logic [COLOR_BITS-1:0]   g0,
  output logic [COLOR_BITS-1:0]   b0,
  output logic [COLOR_BITS-1:0]   r1,
  output logic [COLOR_BITS-1:0]   g1,
  output logic [COLOR_BITS-1:0]   b1,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [5:0]              wr_x,
  input  logic [5:0]              wr_y,
  input  logic [3*COLOR_BITS-1:0] wr_rgb,
  input  logic                    clear_req,
  input  logic [3*COLOR_BITS-1:0] clear_rgb,
  input  logic                    swap_req,
  output logic                    busy,
  output logic                    swap_done
);
  localparam int DW        = 3*COLOR_BITS;
  localparam int AW        = 11;
  localparam int CLEAR_LEN = 32*PANEL_W;

  typedef enum logic [1:0] {IDLE, CLEAR, SWAP_WAIT} state_t;

  state_t          state_q, state_d;
  logic            pend_q, pend_d;
  logic            front_q, front_d;
  logic            sd_q, sd_d;
  logic [11:0]     cnt_q, cnt_d;
  logic [DW-1:0]   clr_q, clr_d;
  logic            sel_q;
  logic            wr_fire, clearing;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdata;
  logic [1:0][1:0][DW-1:0] rdata;
  logic [DW-1:0]   pix0, pix1;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    front_d = front_q;
    cnt_d   = cnt_q;
    clr_d   = clr_q;
    sd_d    = 1'b0;
    case (state_q)
      IDLE:
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
          clr_d   = clear_rgb;
          pend_d  = swap_req;
        end else if (swap_req) begin
          state_d = SWAP_WAIT;
        end
      CLEAR: begin
        cnt_d = cnt_q + 12'd1;
        if (swap_req) pend_d = 1'b1;
        if (cnt_q == 12'(CLEAR_LEN-1)) begin
          state_d = (pend_q || swap_req) ? SWAP_WAIT : IDLE;
          pend_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      SWAP_WAIT:
        if (frame_sync) begin
          front_d = ~front_q;
          sd_d    = 1'b1;
          state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      front_q <= 1'b0;
      sd_q    <= 1'b0;
      cnt_q   <= '0;
      clr_q   <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      front_q <= front_d;
      sd_q    <= sd_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
      sel_q   <= front_q;
    end

  // clear_req suppresses wr_ready so a coincident write is never accepted.
  assign wr_ready  = !rst && state_q == IDLE && !pend_q && !clear_req;
  assign busy      = !rst && state_q != IDLE;
  assign swap_done = !rst && sd_q;

  assign wr_fire  = wr_valid && wr_ready;
  assign clearing = !rst && state_q == CLEAR;
  assign waddr    = clearing ? cnt_q[AW-1:0] : {wr_y[4:0], wr_x};
  assign wdata    = clearing ? clr_q : wr_rgb;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    for (genvar h = 0; h < 2; h++) begin : g_half
      logic we;
      assign we = (1'(b) != front_q) && (clearing || (wr_fire && wr_y[5] == 1'(h)));
      fb_ram #(.DW(DW), .AW(AW)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr ({addry, addrx}),
        .rdata (rdata[b][h])
      );
    end
  end

  assign pix0 = rst ? '0 : rdata[sel_q][0];
  assign pix1 = rst ? '0 : rdata[sel_q][1];
  assign r0 = pix0[COLOR_BITS-1:0];
  assign g0 = pix0[2*COLOR_BITS-1:COLOR_BITS];
  assign b0 = pix0[3*COLOR_BITS-1:2*COLOR_BITS];
  assign r1 = pix1[COLOR_BITS-1:0];
  assign g1 = pix1[2*COLOR_BITS-1:COLOR_BITS];
  assign b1 = pix1[3*COLOR_BITS-1:2*COLOR_BITS];
endmodule

// File: tb/tb_led_framebuf.sv
// Bench for led_framebuf: pixel-array reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.

module tb_led_framebuf;
  localparam int CB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    addrx;
  logic [4:0]    addry;
  logic          frame_sync;
  logic [CB-1:0] r0, g0, b0, r1, g1, b1;
  logic          wr_valid, wr_ready;
  logic [5:0]    wr_x, wr_y;
  logic [3*CB-1:0] wr_rgb, clear_rgb;
  logic          clear_req, swap_req, busy, swap_done;

  led_framebuf #(.COLOR_BITS(CB), .PANEL_W(64)) dut (
    .clk(clk), .rst(rst), .addrx(addrx), .addry(addry), .frame_sync(frame_sync),
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb),
    .clear_req(clear_req), .clear_rgb(clear_rgb), .swap_req(swap_req),
    .busy(busy), .swap_done(swap_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pixel arrays indexed y*64+x, plus remaining clear cycles
  // and a "swap owed" flag.
  logic [3*CB-1:0] mm [2][4096];
  bit              kn [2][4096];
  bit              front, pend, m_sd, m_ok, chk_en;
  int              clear_left;
  logic [3*CB-1:0] col_m, m_p0, m_p1;

  always @(posedge clk) begin
    int ra0, ra1, a, row, cl;
    bit wr_ok;
    if (rst) begin
      clear_left = 0; pend = 0; front = 0; m_sd = 0;
      m_p0 = '0; m_p1 = '0; m_ok = 1;
    end else begin
      ra0  = int'(addry)*64 + int'(addrx);
      ra1  = (int'(addry)+32)*64 + int'(addrx);
      m_p0 = mm[front][ra0];
      m_p1 = mm[front][ra1];
      m_ok = kn[front][ra0] && kn[front][ra1];
      m_sd = 0;
      wr_ok = clear_left == 0 && !pend && !clear_req;
      if (wr_valid && wr_ok) begin
        mm[!front][int'(wr_y)*64 + int'(wr_x)] = wr_rgb;
        kn[!front][int'(wr_y)*64 + int'(wr_x)] = 1;
      end
      if (clear_left > 0) begin
        a = 2048 - clear_left; row = a / 64; cl = a % 64;
        mm[!front][row*64 + cl] = col_m;       kn[!front][row*64 + cl] = 1;
        mm[!front][(row+32)*64 + cl] = col_m;  kn[!front][(row+32)*64 + cl] = 1;
        clear_left--;
        if (swap_req) pend = 1;
      end else if (pend) begin
        if (frame_sync) begin front = !front; pend = 0; m_sd = 1; end
      end else if (clear_req) begin
        clear_left = 2048; col_m = clear_rgb; pend = swap_req;
      end else if (swap_req) begin
        pend = 1;
      end
    end
  end

  int sd_cnt = 0;
  always @(negedge clk) begin
    if (swap_done === 1'b1) sd_cnt++;
    if (chk_en) begin
      chk("busy", busy, !rst && (clear_left > 0 || pend));
      chk("wr_ready", wr_ready, !rst && clear_left == 0 && !pend && !clear_req);
      chk("swap_done", swap_done, !rst && m_sd);
      if (rst) begin
        chk("pix0_rst", {b0, g0, r0}, 0);
        chk("pix1_rst", {b1, g1, r1}, 0);
      end else if (m_ok) begin
        chk("pix0", {b0, g0, r0}, m_p0);
        chk("pix1", {b1, g1, r1}, m_p1);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    clear_req = 0; swap_req = 0; frame_sync = 0; wr_valid = 0;
  endtask

  task automatic pulse_clear(input logic [3*CB-1:0] c);
    clear_rgb = c; clear_req = 1; tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin tick(); n++; end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic swap_now();
    swap_req = 1; tick();
    frame_sync = 1; tick();
  endtask

  initial begin
    int n, sd0;
    bit seen_rdy;
    rst = 1; addrx = 0; addry = 0; frame_sync = 0; wr_valid = 0; wr_x = 0; wr_y = 0;
    wr_rgb = 0; clear_req = 0; clear_rgb = 0; swap_req = 0; chk_en = 0;
    tick();
    chk_en = 1;
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_r0", r0, 0);
    rst = 0; #1;
    chk("post_rst_wr_ready", wr_ready, 1);

    // Known contents in both banks.
    pulse_clear(0); wait_idle(); swap_now();
    pulse_clear(0); wait_idle();

    // Single write to lower half, visible after swap.
    wr_valid = 1; wr_x = 5; wr_y = 40; wr_rgb = 24'h00FF00; tick();
    swap_req = 1; tick();
    frame_sync = 1; tick();
    chk("swap_done_pulse", swap_done, 1);
    tick();
    chk("swap_done_single", swap_done, 0);
    addrx = 5; addry = 8; tick();
    chk("g1_written", g1, 8'hFF);
    chk("r1_written", r1, 8'h00);
    chk("pix0_untouched", {b0, g0, r0}, 0);

    // Clear length and wr_ready low throughout.
    pulse_clear(24'h0000FF);
    n = 0; seen_rdy = 0;
    while (busy && n < 5000) begin
      if (wr_ready) seen_rdy = 1;
      tick(); n++;
    end
    chk("clear_len", n, 2048);
    chk("clear_wr_ready", seen_rdy, 0);
    swap_now();
    for (int a = 0; a < 2048; a++) begin
      addry = 5'(a >> 6); addrx = 6'(a); tick();
    end
    tick();
    chk("sweep_r0", r0, 8'hFF);
    chk("sweep_r1", r1, 8'hFF);

    // Swap requested mid-clear waits for clear end plus frame_sync.
    sd0 = sd_cnt;
    pulse_clear(24'h123456);
    repeat (99) tick();
    swap_req = 1; tick();
    repeat (399) tick();
    frame_sync = 1; tick();
    tick();
    chk("no_swap_midclear", sd_cnt, sd0);
    repeat (1700) tick();
    chk("swap_wait_busy", busy, 1);
    frame_sync = 1; tick();
    chk("swap_after_clear", swap_done, 1);
    tick();
    chk("swap_once", sd_cnt, sd0 + 1);

    // swap_req coincident with frame_sync defers to the next frame_sync.
    addrx = 10; addry = 3;
    swap_req = 1; frame_sync = 1; tick();
    chk("coincident_no_swap", swap_done, 0);
    chk("coincident_busy", busy, 1);
    repeat (5) tick();
    frame_sync = 1; tick();
    chk("deferred_swap", swap_done, 1);
    chk("read_old_front", r0, 8'h56);
    tick();
    chk("read_new_front", r0, 8'hFF);

    // Reset mid-clear.
    sd0 = sd_cnt;
    pulse_clear(24'hABCDEF);
    repeat (999) tick();
    rst = 1; #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_r0", r0, 0);
    tick();
    rst = 0; #1;
    chk("rel_busy", busy, 0);
    chk("rel_wr_ready", wr_ready, 1);
    chk("rel_r0", r0, 0);
    repeat (3) begin frame_sync = 1; tick(); end
    tick();
    chk("rst_no_swap", sd_cnt, sd0);
    addrx = 0; addry = 0; tick();
    chk("front0_cleared_part", r0, 8'hEF);
    addrx = 63; addry = 31; tick();
    chk("front0_old_part", r0, 8'h56);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      addrx      = 6'($urandom);
      addry      = 5'($urandom);
      wr_valid   = 1'($urandom);
      wr_x       = 6'($urandom);
      wr_y       = 6'($urandom);
      wr_rgb     = 24'($urandom);
      clear_rgb  = 24'($urandom);
      clear_req  = ($urandom_range(0, 299) == 0);
      swap_req   = ($urandom_range(0, 59) == 0);
      frame_sync = ($urandom_range(0, 49) == 0);
      rst        = ($urandom_range(0, 999) == 0);
      @(posedge clk); #1;
      rst = 0;
    end
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
